// File: rtl/sap_controller_if.sv
// Control-bus bundle between the SAP sequencer and its datapath registers.
// run/opcode flow into the sequencer; load and bus-enable strobes flow out.
interface sap_controller_if #(
  parameter int OP_W = 4
) ();
  // run is a level-sensitive advance enable, not a valid/ready pair: while
  // run=1 the sequencer moves one T-state per clock; while run=0 it holds its
  // state and keeps driving that state's strobes, so downstream loads repeat.
  logic            run;
  logic [OP_W-1:0] opcode;
  logic            cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  logic [2:0]      t_state;
  logic            halted;

  modport master (
    input  run, opcode,
    output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, t_state, halted
  );

  modport slave (
    output run, opcode,
    input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, t_state, halted
  );
endinterface

// File: rtl/sap_controller.sv
// Six-state T-ring sequencer for the 4-bit accumulator CPU: decodes state and
// IR opcode into register load / bus-enable strobes, with a sticky HALT state.
module sap_controller #(
  parameter int              OP_W   = 4,
  parameter logic [OP_W-1:0] OP_LDA = 4'b0000,
  parameter logic [OP_W-1:0] OP_ADD = 4'b0001,
  parameter logic [OP_W-1:0] OP_SUB = 4'b0010,
  parameter logic [OP_W-1:0] OP_OUT = 4'b1110,
  parameter logic [OP_W-1:0] OP_HLT = 4'b1111
) (
  input logic               clk,
  input logic               clr,
  sap_controller_if.master  bus
);

  // Binary encoding chosen so the state register doubles as t_state.
  localparam logic [2:0] ST_HALT = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;
  localparam logic [2:0] ST_T5   = 3'd5;
  localparam logic [2:0] ST_T6   = 3'd6;

  logic [2:0] state;
  logic [2:0] state_nxt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_T1;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state > ST_T6) begin
      // Unused encoding 7: recover to the start of an instruction.
      state_nxt = ST_T1;
    end else if (state != ST_HALT && bus.run) begin
      case (state)
        ST_T1:   state_nxt = ST_T2;
        ST_T2:   state_nxt = ST_T3;
        ST_T3:   state_nxt = ST_T4;
        ST_T4:   state_nxt = (bus.opcode == OP_HLT) ? ST_HALT : ST_T5;
        ST_T5:   state_nxt = ST_T6;
        ST_T6:   state_nxt = ST_T1;
        default: state_nxt = ST_T1;
      endcase
    end
  end

  always_comb begin
    bus.cp = 1'b0;
    bus.ep = 1'b0;
    bus.lm = 1'b0;
    bus.ce = 1'b0;
    bus.li = 1'b0;
    bus.ei = 1'b0;
    bus.la = 1'b0;
    bus.ea = 1'b0;
    bus.su = 1'b0;
    bus.eu = 1'b0;
    bus.lb = 1'b0;
    bus.lo = 1'b0;
    case (state)
      ST_T1: begin
        bus.ep = 1'b1;
        bus.lm = 1'b1;
      end
      ST_T2: bus.cp = 1'b1;
      ST_T3: begin
        bus.ce = 1'b1;
        bus.li = 1'b1;
      end
      ST_T4: begin
        if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          bus.ei = 1'b1;
          bus.lm = 1'b1;
        end else if (bus.opcode == OP_OUT) begin
          bus.ea = 1'b1;
          bus.lo = 1'b1;
        end
      end
      ST_T5: begin
        if (bus.opcode == OP_LDA) begin
          bus.ce = 1'b1;
          bus.la = 1'b1;
        end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          bus.ce = 1'b1;
          bus.lb = 1'b1;
        end
      end
      ST_T6: begin
        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          bus.eu = 1'b1;
          bus.la = 1'b1;
          bus.su = (bus.opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  assign bus.t_state = state;
  assign bus.halted  = (state == ST_HALT);

endmodule

// File: tb/tb_sap_controller.sv
// Scenario bench for sap_controller: expected per-cycle strobe vectors are
// queued per scenario and popped against the DUT at each falling edge.
module tb_sap_controller;

  // Vector layout: {halted, t_state[2:0], cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
  localparam logic [11:0] S_CP = 12'b1000_0000_0000;
  localparam logic [11:0] S_EP = 12'b0100_0000_0000;
  localparam logic [11:0] S_LM = 12'b0010_0000_0000;
  localparam logic [11:0] S_CE = 12'b0001_0000_0000;
  localparam logic [11:0] S_LI = 12'b0000_1000_0000;
  localparam logic [11:0] S_EI = 12'b0000_0100_0000;
  localparam logic [11:0] S_LA = 12'b0000_0010_0000;
  localparam logic [11:0] S_EA = 12'b0000_0001_0000;
  localparam logic [11:0] S_SU = 12'b0000_0000_1000;
  localparam logic [11:0] S_EU = 12'b0000_0000_0100;
  localparam logic [11:0] S_LB = 12'b0000_0000_0010;
  localparam logic [11:0] S_LO = 12'b0000_0000_0001;
  localparam logic [11:0] S_NONE = 12'b0;

  logic clk = 1'b0;
  logic clr;
  int   tests_run = 0;
  int   fails = 0;
  logic [15:0] exp_q[$];

  sap_controller_if #(.OP_W(4)) bus ();

  sap_controller dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] ev(input logic h, input logic [2:0] t, input logic [11:0] s);
    return {h, t, s};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.halted, bus.t_state, bus.cp, bus.ep, bus.lm, bus.ce, bus.li, bus.ei,
            bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo};
  endfunction

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Bus exclusivity monitor: at most one source drives the bus per cycle.
  always @(negedge clk) begin
    tests_run++;
    if ($countones({bus.ep, bus.ce, bus.ei, bus.ea, bus.eu}) > 1) begin
      fails++;
      $display("FAIL bus_onehot t=%0t: got enables %b, required at most one set", $time,
               {bus.ep, bus.ce, bus.ei, bus.ea, bus.eu});
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] e, g;
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    exp_q.push_back(ev(0, 3'd5, S_CE | S_LA));
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    clr = 1'b1; bus.run = 1'b0; bus.opcode = 4'b0000;
    @(negedge clk); @(negedge clk);
    e = exp_q.pop_front(); g = obs(); tests_run++;
    if (g !== e) begin fails++; $display("FAIL reset_initial: got %h required %h", g, e); end
    clr = 1'b0; bus.run = 1'b1;
    repeat (4) advance();
    e = exp_q.pop_front(); g = obs(); tests_run++;
    if (g !== e) begin fails++; $display("FAIL reset_pre_t5: got %h required %h", g, e); end
    #2 clr = 1'b1;
    #1;
    e = exp_q.pop_front(); g = obs(); tests_run++;
    if (g !== e) begin fails++; $display("FAIL reset_async_mid_t5: got %h required %h", g, e); end
    advance();
    e = exp_q.pop_front(); g = obs(); tests_run++;
    if (g !== e) begin fails++; $display("FAIL reset_held: got %h required %h", g, e); end
    clr = 1'b0;
  endtask

  task automatic test_lda();
    logic [15:0] e, g;
    bus.opcode = 4'b0000; bus.run = 1'b1;
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    exp_q.push_back(ev(0, 3'd2, S_CP));
    exp_q.push_back(ev(0, 3'd3, S_CE | S_LI));
    exp_q.push_back(ev(0, 3'd4, S_EI | S_LM));
    exp_q.push_back(ev(0, 3'd5, S_CE | S_LA));
    exp_q.push_back(ev(0, 3'd6, S_NONE));
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    for (int i = 0; i < 7; i++) begin
      e = exp_q.pop_front(); g = obs(); tests_run++;
      if (g !== e) begin fails++; $display("FAIL lda step %0d: got %h required %h", i, g, e); end
      if (i < 6) advance();
    end
  endtask

  task automatic test_add_sub();
    logic [15:0] e, g;
    logic [3:0]  op;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
      exp_q.push_back(ev(0, 3'd2, S_CP));
      exp_q.push_back(ev(0, 3'd3, S_CE | S_LI));
      exp_q.push_back(ev(0, 3'd4, S_EI | S_LM));
      exp_q.push_back(ev(0, 3'd5, S_CE | S_LB));
      exp_q.push_back(ev(0, 3'd6, (k == 0) ? (S_EU | S_LA) : (S_EU | S_LA | S_SU)));
    end
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    bus.run = 1'b1;
    for (int i = 0; i < 13; i++) begin
      op = (i < 6) ? 4'b0001 : 4'b0010;
      // Opcode is scrambled during fetch; it must not influence T1..T3.
      bus.opcode = ((i % 6) < 3) ? 4'($urandom_range(0, 15)) : op;
      #1;
      e = exp_q.pop_front(); g = obs(); tests_run++;
      if (g !== e) begin fails++; $display("FAIL add_sub step %0d: got %h required %h", i, g, e); end
      if (i < 12) advance();
    end
  endtask

  task automatic test_out_nop();
    logic [15:0] e, g;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
      exp_q.push_back(ev(0, 3'd2, S_CP));
      exp_q.push_back(ev(0, 3'd3, S_CE | S_LI));
      exp_q.push_back(ev(0, 3'd4, (k == 0) ? (S_EA | S_LO) : S_NONE));
      exp_q.push_back(ev(0, 3'd5, S_NONE));
      exp_q.push_back(ev(0, 3'd6, S_NONE));
    end
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    bus.run = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.opcode = (i < 6) ? 4'b1110 : 4'b0101;
      #1;
      e = exp_q.pop_front(); g = obs(); tests_run++;
      if (g !== e) begin fails++; $display("FAIL out_nop step %0d: got %h required %h", i, g, e); end
      if (i < 12) advance();
    end
  endtask

  task automatic test_stall();
    logic [15:0] e, g;
    bus.opcode = 4'b0000;
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    exp_q.push_back(ev(0, 3'd2, S_CP));
    repeat (4) exp_q.push_back(ev(0, 3'd3, S_CE | S_LI));
    exp_q.push_back(ev(0, 3'd4, S_EI | S_LM));
    exp_q.push_back(ev(0, 3'd5, S_CE | S_LA));
    exp_q.push_back(ev(0, 3'd6, S_NONE));
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front(); g = obs(); tests_run++;
      if (g !== e) begin fails++; $display("FAIL stall step %0d: got %h required %h", i, g, e); end
      bus.run = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
      if (i < 9) advance();
    end
  endtask

  task automatic test_halt();
    logic [15:0] e, g;
    bus.opcode = 4'b1111; bus.run = 1'b1;
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    exp_q.push_back(ev(0, 3'd2, S_CP));
    exp_q.push_back(ev(0, 3'd3, S_CE | S_LI));
    exp_q.push_back(ev(0, 3'd4, S_NONE));
    repeat (11) exp_q.push_back(ev(1, 3'd0, S_NONE));
    for (int i = 0; i < 15; i++) begin
      e = exp_q.pop_front(); g = obs(); tests_run++;
      if (g !== e) begin fails++; $display("FAIL halt step %0d: got %h required %h", i, g, e); end
      if (i >= 4) begin
        bus.run    = 1'($urandom_range(0, 1));
        bus.opcode = 4'($urandom_range(0, 15));
      end
      if (i < 14) advance();
    end
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    exp_q.push_back(ev(0, 3'd1, S_EP | S_LM));
    #2 clr = 1'b1;
    #1;
    e = exp_q.pop_front(); g = obs(); tests_run++;
    if (g !== e) begin fails++; $display("FAIL halt_clr_async: got %h required %h", g, e); end
    advance();
    clr = 1'b0; bus.run = 1'b1; bus.opcode = 4'b0000;
    e = exp_q.pop_front(); g = obs(); tests_run++;
    if (g !== e) begin fails++; $display("FAIL halt_clr_release: got %h required %h", g, e); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_lda();
    test_add_sub();
    test_out_nop();
    test_stall();
    test_halt();
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    tests_run++;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
- Control sequencer for the 4-bit accumulator CPU.
- Sits directly upstream of the `register` instances (PC, MAR, IR, A, B, OUT). It drives their `load` strobes, and the bus-enable strobes of their sources, from a 6-state T-state ring and the IR opcode.
- The datapath registers consume its outputs on the following rising `clk`.
- A halt state freezes the machine until reset.

Parameters:
- OP_W, 4, opcode width (upper nibble of IR).
- OP_LDA, 4'b0000, load A from memory.
- OP_ADD, 4'b0001, A <= A + mem.
- OP_SUB, 4'b0010, A <= A - mem.
- OP_OUT, 4'b1110, OUT <= A.
- OP_HLT, 4'b1111, halt.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- clr  input  1  reset, asynchronous, active-high.
- run  input  1  1 = sequencer advances each cycle; 0 = hold current state.
- opcode  input  OP_W  IR upper nibble; valid from T4 onward.
- cp  output  1  PC increment.
- ep  output  1  PC drives bus.
- lm  output  1  MAR load.
- ce  output  1  RAM drives bus.
- li  output  1  IR load.
- ei  output  1  IR operand drives bus.
- la  output  1  A load.
- ea  output  1  A drives bus.
- su  output  1  ALU subtract select.
- eu  output  1  ALU drives bus.
- lb  output  1  B load.
- lo  output  1  OUT load.
- t_state  output  3  current state index: 1..6 for T1..T6, 0 when halted.
- halted  output  1  1 in HALT state.

Behaviour:
- States: T1..T6, HALT. Single state register, one-hot or binary (implementer's choice). The t_state encoding is fixed as above.
- Reset (clr=1, asynchronous): state <= T1 immediately, regardless of clk. Outputs during and after reset:
  - T1 strobes: ep=1, lm=1.
  - All other strobes 0, halted=0, t_state=1.
- Transitions on rising clk when clr=0:
  - run=0: hold state.
  - run=1: T1->T2->T3->T4->T5->T6->T1.
  - T4 with opcode==OP_HLT and run=1: go to HALT instead of T5.
  - HALT: stays in HALT until clr, independent of run.
- Strobes are combinational decode of state and opcode. Every strobe not listed for a state/opcode below is 0.
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
  - T4:
    - LDA/ADD/SUB: ei, lm.
    - OUT: ea, lo.
    - HLT: none.
    - Undefined opcode: none (NOP).
  - T5:
    - LDA: ce, la.
    - ADD/SUB: ce, lb.
    - Other opcodes: none.
  - T6:
    - ADD: eu, la.
    - SUB: eu, la, su.
    - Other opcodes: none.
  - HALT: all strobes 0.
- Strobes are not gated by run. When run=0 the current state's strobes stay asserted, so downstream loads repeat. Software guarantees only idempotent states are stalled; this is the intended behaviour.
- Bus exclusivity invariant: at most one of {ep, ce, ei, ea, eu} is 1 in any cycle, including undefined opcodes.
- Fixed timing: every non-HLT instruction takes exactly 6 cycles with run=1. HLT reaches HALT at the 4th edge after T1.
- opcode changes outside T4..T6 have no effect on state or strobes.
- Reset mid-instruction: returns to T1 asynchronously. The partial instruction is abandoned and no further strobes from it are issued.

Test Plan:
- Reset: assert clr mid-T5 with opcode=0000, asynchronously between edges -> same delta: t_state=1, ep=1, lm=1, la=0, halted=0.
- LDA: run=1, opcode=0000, one 6-cycle pass -> strobe sets per cycle {ep,lm}, {cp}, {ce,li}, {ei,lm}, {ce,la}, {}; then t_state=1.
- ADD then SUB:
  - opcode=0001 -> T6 = {eu,la}, su=0.
  - Next instruction opcode=0010 -> T6 = {eu,la,su}.
  - T4/T5 identical to LDA except T5 has lb in place of la.
- OUT and NOP:
  - opcode=1110 -> T4 = {ea,lo}, T5/T6 empty.
  - opcode=0101 -> T4..T6 all strobes 0.
  - Both: t_state wraps 6->1.
- Stall: run=0 during T3 for 3 cycles -> t_state stays 3 with ce=1, li=1 held. run=1 -> T4 on the next edge.
- Halt: opcode=1111 -> T4 has all strobes 0; next edge halted=1, t_state=0. Stays halted for 10 cycles with run toggled. clr -> t_state=1, halted=0.
- Every scenario: bus-enable one-hot-or-zero assertion checked each cycle.
